// File: rtl/sc_lifo_burst_reader_if.sv
// Bus bundle between the burst reader, its command source, the LIFO read port
// and the downstream word stream. The master view is the reader itself.
interface sc_lifo_burst_reader_if #(
  parameter int data_width = 32,
  parameter int lifo_depth = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [lifo_depth:0]   cmd_len;
  logic                  lifo_rd;
  logic [data_width-1:0] lifo_data;
  logic                  lifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [data_width-1:0] m_data;
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_len, lifo_data, lifo_empty, m_ready,
    output cmd_ready, lifo_rd, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_len, lifo_data, lifo_empty, m_ready,
    input  cmd_ready, lifo_rd, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sc_lifo_burst_reader.sv
// Pops a commanded number of words from a 1-cycle-latency LIFO and replays
// them as a valid/ready stream with a last marker, through a 2-entry skid.
module sc_lifo_burst_reader #(
  parameter int data_width = 32,
  parameter int lifo_depth = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  sc_lifo_burst_reader_if.master bus,
  output logic                   busy,
  output logic                   done
);
  localparam int LW = lifo_depth + 1;
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [LW-1:0]                  rd_left_q, rd_left_d;
  logic [LW-1:0]                  out_left_q, out_left_d;
  logic [1:0][data_width-1:0]     skid_q, skid_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic                           inflight_q, inflight_d;
  logic                           done_q, done_d;
  logic                           rd, pop, m_valid;

  // Reads only from registered state: the occupancy bound counts the word
  // still in flight so the skid can never overflow, whatever m_ready does.
  assign rd = (state_q == RUN) && (rd_left_q != '0) && !bus.lifo_empty &&
              ((cnt_q + {1'b0, inflight_q}) < 2'd2);
  assign m_valid = (cnt_q != 2'd0);
  assign pop     = m_valid && bus.m_ready;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.lifo_rd   = rd;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = skid_q[0];
  assign bus.m_last    = m_valid && (out_left_q == ONE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // Skid: entry 0 is the head; a write lands behind whatever survives the pop.
  always_comb begin
    skid_d     = skid_q;
    cnt_d      = cnt_q;
    inflight_d = rd;
    case ({inflight_q, pop})
      2'b10: begin
        skid_d[cnt_q[0]] = bus.lifo_data;
        cnt_d            = cnt_q + 2'd1;
      end
      2'b01: begin
        skid_d[0] = skid_q[1];
        cnt_d     = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          skid_d[0] = bus.lifo_data;
        end else begin
          skid_d[0] = skid_q[1];
          skid_d[1] = bus.lifo_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    if (rd)  rd_left_d  = rd_left_q - ONE;
    if (pop) out_left_d = out_left_q - ONE;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            rd_left_d  = bus.cmd_len;
            out_left_d = bus.cmd_len;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (rd && (rd_left_q == ONE)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (out_left_q == ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_left_q  <= '0;
      out_left_q <= '0;
      skid_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_sc_lifo_burst_reader.sv
// Bench for sc_lifo_burst_reader: behavioural LIFO, table-driven bursts,
// hand-written corner sequences and a randomized push/ready soak.
module tb_sc_lifo_burst_reader;
  localparam int DW   = 32;
  localparam int LD   = 12;
  localparam int LW   = LD + 1;
  localparam int LCAP = 1 << LD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, done;
  always #5 clk = ~clk;

  sc_lifo_burst_reader_if #(.data_width(DW), .lifo_depth(LD)) bus();
  sc_lifo_burst_reader #(.data_width(DW), .lifo_depth(LD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done(done)
  );

  // LIFO model: stack with registered read data; every pop is logged in order
  logic [DW-1:0] stk [LCAP];
  logic [DW-1:0] plog [65536];
  int            sp = 0, pcnt = 0;
  logic [DW-1:0] dout = '0;
  logic          push = 1'b0, flush = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          m_pop, m_push;

  assign m_pop          = !flush && bus.lifo_rd && (sp > 0);
  assign m_push         = !flush && push && (sp < LCAP);
  assign bus.lifo_empty = (sp == 0);
  assign bus.lifo_data  = dout;

  always @(posedge clk) begin
    if (flush) begin
      sp <= 0;
    end else begin
      if (m_pop) begin
        dout               <= stk[sp-1];
        plog[pcnt[15:0]]   <= stk[sp-1];
        pcnt               <= pcnt + 1;
      end
      if (m_push) stk[m_pop ? sp-1 : sp] <= push_data;
      sp <= sp - int'(m_pop) + int'(m_push);
    end
  end

  int n_vec = 0, n_err = 0;
  int n_done = 0, n_rd = 0, pbase = 0;
  int rdy_pct = 0, push_pct = 0;
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            cmd_q[$];
  logic          stall_p = 1'b0, last_p = 1'b0;
  logic [DW-1:0] data_p = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endfunction

  // Negedge observer: stream hold rule, read legality, handshakes, done pulses
  function automatic void mon();
    if (reset) begin
      stall_p = 1'b0;
      return;
    end
    if (stall_p) begin
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_data", bus.m_data, data_p);
      chk("hold_last", bus.m_last, last_p);
    end
    if (bus.lifo_rd) begin
      n_rd++;
      chk("rd_when_empty", bus.lifo_empty, 0);
    end
    if (bus.m_valid && bus.m_ready) begin
      got_d.push_back(bus.m_data);
      got_l.push_back(bus.m_last);
    end
    if (bus.cmd_valid && bus.cmd_ready) cmd_q.push_back(int'(bus.cmd_len));
    if (done) n_done++;
    stall_p = bus.m_valid && !bus.m_ready;
    data_p  = bus.m_data;
    last_p  = bus.m_last;
  endfunction

  task automatic tick();
    if (push_pct > 0) begin
      push      = (sp < LCAP - 16) && ($urandom_range(0, 99) < push_pct);
      push_data = $urandom;
    end
    bus.m_ready = ($urandom_range(0, 99) < rdy_pct);
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_book();
    got_d.delete();
    got_l.delete();
    cmd_q.delete();
    n_done = 0;
    n_rd   = 0;
    pbase  = pcnt;
  endtask

  task automatic flush_lifo();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_one(logic [DW-1:0] v);
    push = 1'b1;
    push_data = v;
    tick();
    push = 1'b0;
  endtask

  task automatic push_seq(int n);
    for (int i = 0; i < n; i++) push_one(DW'((i + 1) * 32'h11));
  endtask

  task automatic send_cmd(int len);
    int n0;
    n0 = cmd_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    for (int i = 0; i < 200 && cmd_q.size() == n0; i++) tick();
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", cmd_q.size(), n0 + 1);
  endtask

  task automatic wait_done(int target, int budget);
    for (int i = 0; i < budget && n_done < target; i++) tick();
    chk("done_count", n_done, target);
  endtask

  task automatic chk_out(string nm, logic [DW-1:0] exp[$]);
    chk({nm, "_n"}, got_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_d.size(); i++) begin
      chk({nm, "_data"}, got_d[i], exp[i]);
      chk({nm, "_last"}, got_l[i], (i == exp.size() - 1));
    end
  endtask

  typedef struct {
    int npush;
    int len;
    int rdy;
    int exp_words;
    int exp_left;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [DW-1:0] exp[$];
    int idx, tot;

    tbl[0] = '{npush: 4, len: 4, rdy: 100, exp_words: 4, exp_left: 0};
    tbl[1] = '{npush: 8, len: 3, rdy: 50,  exp_words: 3, exp_left: 5};
    tbl[2] = '{npush: 5, len: 1, rdy: 100, exp_words: 1, exp_left: 4};
    tbl[3] = '{npush: 6, len: 6, rdy: 30,  exp_words: 6, exp_left: 0};
    tbl[4] = '{npush: 3, len: 0, rdy: 100, exp_words: 0, exp_left: 3};

    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_lifo_rd", bus.lifo_rd, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // table-driven bursts; pushed words are k*0x11, so the top is npush*0x11
    for (int k = 0; k < 5; k++) begin
      flush_lifo();
      clear_book();
      rdy_pct = 0;
      push_seq(tbl[k].npush);
      rdy_pct = tbl[k].rdy;
      send_cmd(tbl[k].len);
      if (tbl[k].len == 0) begin
        chk("zl_done", done, 1);
        chk("zl_busy", busy, 0);
      end
      wait_done(1, 400);
      exp.delete();
      for (int j = 0; j < tbl[k].exp_words; j++)
        exp.push_back(DW'((tbl[k].npush - j) * 32'h11));
      chk_out("tbl", exp);
      chk("tbl_left", sp, tbl[k].exp_left);
      if (tbl[k].len == 0) chk("zl_no_rd", n_rd, 0);
    end

    // downstream stalled: two reads fill the skid, then reads stop
    flush_lifo();
    clear_book();
    rdy_pct = 0;
    push_seq(8);
    send_cmd(3);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_rd", n_rd, 2);
    chk("stall_out", got_d.size(), 0);
    chk("stall_busy", busy, 1);
    rdy_pct = 100;
    wait_done(1, 100);
    chk("stall_rd_total", n_rd, 3);
    exp = '{32'h88, 32'h77, 32'h66};
    chk_out("stall", exp);
    chk("stall_left", sp, 5);

    // LIFO runs dry mid-burst; late pushes are consumed as they arrive
    flush_lifo();
    clear_book();
    rdy_pct = 0;
    push_seq(2);
    rdy_pct = 100;
    send_cmd(5);
    for (int i = 0; i < 10; i++) tick();
    chk("dry_out", got_d.size(), 2);
    chk("dry_busy", busy, 1);
    chk("dry_rd", n_rd, 2);
    push_one(32'hA); tick(); tick();
    push_one(32'hB); tick(); tick();
    push_one(32'hC);
    wait_done(1, 100);
    exp = '{32'h22, 32'h11, 32'hA, 32'hB, 32'hC};
    chk_out("dry", exp);

    // reset with a full skid, then a fresh single-word burst
    flush_lifo();
    clear_book();
    rdy_pct = 0;
    push_seq(8);
    send_cmd(5);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_rd", n_rd, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_m_valid", bus.m_valid, 0);
    chk("mid_cmd_ready", bus.cmd_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_lifo_rd", bus.lifo_rd, 0);
    clear_book();
    rdy_pct = 100;
    send_cmd(1);
    wait_done(1, 100);
    exp = '{32'h66};
    chk_out("post_rst", exp);
    chk("post_rst_left", sp, 5);

    // soak: random pushes, random ready, random command lengths
    flush_lifo();
    clear_book();
    rdy_pct  = 50;
    push_pct = 40;
    for (int c = 0; c < 10000; c++) begin
      int nq;
      nq = cmd_q.size();
      if (!bus.cmd_valid && $urandom_range(0, 99) < 20) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'($urandom_range(0, 6));
      end
      tick();
      if (cmd_q.size() != nq) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    wait_done(cmd_q.size(), 4000);
    push_pct = 0;
    push = 1'b0;
    tot = 0;
    foreach (cmd_q[c]) tot += cmd_q[c];
    chk("rand_total", got_d.size(), tot);
    chk("rand_pops", got_d.size(), pcnt - pbase);
    for (int i = 0; i < got_d.size() && i < pcnt - pbase; i++)
      chk("rand_data", got_d[i], plog[(pbase + i) & 16'hFFFF]);
    idx = 0;
    foreach (cmd_q[c]) begin
      for (int j = 0; j < cmd_q[c]; j++) begin
        if (idx < got_l.size()) chk("rand_last", got_l[idx], (j == cmd_q[c] - 1));
        idx++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
